// File: rtl/sysid_read_master_if.sv
// ---------------------------------------------------------------------------
// sysid_read_master_if
//   Avalon-MM read-only bus between the system-ID read master and the
//   system-ID slave. Single-bit word address (0 = ID, 1 = build timestamp),
//   zero-latency read data qualified by waitrequest.
//
//   Signals:
//     address      master -> slave  word select
//     read         master -> slave  read strobe
//     waitrequest  slave  -> master stall; transfer completes when low with read high
//     readdata     slave  -> master 32-bit data, valid on the completing edge
//
//   Modports: master (read master side), slave (system-ID slave side).
// ---------------------------------------------------------------------------
interface sysid_read_master_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata
  );
endinterface

// File: rtl/sysid_read_master.sv
// ---------------------------------------------------------------------------
// sysid_read_master
//   On request, reads word 0 (system ID) and word 1 (build timestamp) from the
//   system-ID slave, compares each against the expected build constants and
//   reports the result to the boot/status logic, so an FPGA image / software
//   mismatch is caught before the CPU is released.
//
//   Optional feature: define SYSID_TIMEOUT_EN to bound every read by
//   TIMEOUT_CYCLES stalled edges; without it reads wait indefinitely and the
//   timeout output is tied low.
//
//   Ports:
//     clock     in   system clock, rising edge
//     reset     in   synchronous active-high reset
//     start     in   request a check (ignored while busy)
//     avm       if   Avalon-MM master modport (address, read, waitrequest, readdata)
//     busy      out  check in progress
//     done      out  result valid; held until the next accepted start or reset
//     id_ok     out  captured ID equals EXPECTED_ID
//     ts_ok     out  captured timestamp equals EXPECTED_TS
//     pass      out  id_ok & ts_ok & ~timeout
//     timeout   out  a read exceeded TIMEOUT_CYCLES stalled edges
//     id_value  out  last captured ID word
//     ts_value  out  last captured timestamp word
// ---------------------------------------------------------------------------
module sysid_read_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h1111_1111,
  parameter logic [31:0] EXPECTED_TS    = 32'h52F1_3D16,
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  sysid_read_master_if.master        avm,
  output logic                       busy,
  output logic                       done,
  output logic                       id_ok,
  output logic                       ts_ok,
  output logic                       pass,
  output logic                       timeout,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value
);

  // A zero timeout would abort every stalled read immediately.
  if (TIMEOUT_CYCLES < 32'd1) begin : g_timeout_range
    $error("sysid_read_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        address_r, address_s;
  logic        read_r, read_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        id_ok_r, id_ok_s;
  logic        ts_ok_r, ts_ok_s;
  logic        pass_r, pass_s;
  logic        timeout_r, timeout_s;
  logic [31:0] id_value_r, id_value_s;
  logic [31:0] ts_value_r, ts_value_s;
  logic        stall_expired_s;

`ifdef SYSID_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;

  // Stall counter: counts stalled edges of the current read. It is zero
  // whenever no stall is in progress, so it is zero on entering each RD state.
  always_comb begin
    wait_cnt_s = wait_cnt_r;
    if ((state_r == RD_ID || state_r == RD_TS) && avm.waitrequest) begin
      wait_cnt_s = wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_s = '0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // This edge is the TIMEOUT_CYCLES-th stalled edge of the current read.
  assign stall_expired_s = avm.waitrequest && (wait_cnt_r == CNT_LAST);
`else
  assign stall_expired_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is computed here and
  // registered below.
  always_comb begin
    state_s    = state_r;
    address_s  = address_r;
    read_s     = read_r;
    busy_s     = busy_r;
    done_s     = done_r;
    id_ok_s    = id_ok_r;
    ts_ok_s    = ts_ok_r;
    pass_s     = pass_r;
    timeout_s  = timeout_r;
    id_value_s = id_value_r;
    ts_value_s = ts_value_r;

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s   = RD_ID;
          address_s = 1'b0;
          read_s    = 1'b1;
          busy_s    = 1'b1;
          done_s    = 1'b0;
          id_ok_s   = 1'b0;
          ts_ok_s   = 1'b0;
          pass_s    = 1'b0;
          timeout_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      RD_ID, RD_TS: begin
        if (stall_expired_s) begin
          // Abandon the read; the flag of the unread word stays 0.
          state_s   = DONE;
          read_s    = 1'b0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          pass_s    = 1'b0;
          timeout_s = 1'b1;
        end else if (!avm.waitrequest) begin
          if (state_r == RD_ID) begin
            state_s    = RD_TS;
            address_s  = 1'b1;
            id_value_s = avm.readdata;
            id_ok_s    = (avm.readdata == EXPECTED_ID);
          end else begin
            state_s    = DONE;
            read_s     = 1'b0;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            ts_value_s = avm.readdata;
            ts_ok_s    = (avm.readdata == EXPECTED_TS);
            // timeout cannot be set on a completing edge, so it drops out here.
            pass_s     = id_ok_r && (avm.readdata == EXPECTED_TS);
          end
        end else begin
          // Stalled: address and read stay as registered.
          state_s = state_r;
        end
      end

      default: begin
        state_s = IDLE;
        read_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      address_r  <= 1'b0;
      read_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      id_ok_r    <= 1'b0;
      ts_ok_r    <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      id_value_r <= 32'h0000_0000;
      ts_value_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      address_r  <= address_s;
      read_r     <= read_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      id_ok_r    <= id_ok_s;
      ts_ok_r    <= ts_ok_s;
      pass_r     <= pass_s;
      timeout_r  <= timeout_s;
      id_value_r <= id_value_s;
      ts_value_r <= ts_value_s;
    end
  end

  assign avm.address = address_r;
  assign avm.read    = read_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_ok       = id_ok_r;
  assign ts_ok       = ts_ok_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule
